// File: rtl/regfile.sv
// regfile: operand register file and flags register feeding the 8-bit ALU.
//
// Eight general registers (r0 hard-wired to zero). Two registered read
// ports present operands on a/b. Writeback from the ALU goes into r1..r7.
// A 4-bit flags register latches the ALU's {z,n,c,v}. A combinational
// condition evaluator on the latched flags drives branch decisions.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   rd_a_sel  register selected onto a
//   rd_b_sel  register selected onto b
//   hold      1 = a/b keep their value (writes and flag loads still occur)
//   a, b      registered operands to the ALU
//   wr_en     register write strobe
//   wr_sel    register written (writes to r0 are discarded)
//   wr_data   writeback data
//   flags_en  flags register load strobe
//   flags_in  ALU flags {z,n,c,v}
//   flags     latched flags {z,n,c,v}
//   cond      condition code
//   cond_true 1 when cond holds on the latched flags
module regfile #(
  parameter int WIDTH = 8,
  parameter int REGS  = 8,
  localparam int SEL_W = $clog2(REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] rd_a_sel,
  input  logic [SEL_W-1:0] rd_b_sel,
  input  logic             hold,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             flags_en,
  input  logic [3:0]       flags_in,
  output logic [3:0]       flags,
  input  logic [2:0]       cond,
  output logic             cond_true
);

  // mem[0] is reset and never written, so it always holds zero; reads of r0
  // are still forced to zero explicitly so bypass cannot leak into it.
  logic [WIDTH-1:0] mem [REGS];

  logic wr_live;
  assign wr_live = wr_en && (wr_sel != '0);

  // Read value with write-through bypass: a write landing on the same edge
  // is what the read port loads.
  function automatic logic [WIDTH-1:0] read_port(input logic [SEL_W-1:0] sel);
    if (sel == '0)
      return '0;
    else if (wr_live && (wr_sel == sel))
      return wr_data;
    else
      return mem[sel];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (wr_live) begin
      mem[wr_sel] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
    end else if (!hold) begin
      a <= read_port(rd_a_sel);
      b <= read_port(rd_b_sel);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flags <= '0;
    else if (flags_en)
      flags <= flags_in;
  end

  logic fz, fn, fc, fv;
  assign {fz, fn, fc, fv} = flags;

  always_comb begin
    cond_true = 1'b1;
    case (cond)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = fz;
      3'b010: cond_true = !fz;
      3'b011: cond_true = fc;
      3'b100: cond_true = !fc;
      3'b101: cond_true = fn;
      3'b110: cond_true = fn ^ fv;
      3'b111: cond_true = !(fn ^ fv);
      default: cond_true = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rd_a_sel, rd_b_sel, wr_sel, cond;
  logic       hold, wr_en, flags_en;
  logic [7:0] a, b, wr_data;
  logic [3:0] flags_in, flags;
  logic       cond_true;

  regfile dut (
    .clk(clk), .rst(rst),
    .rd_a_sel(rd_a_sel), .rd_b_sel(rd_b_sel), .hold(hold),
    .a(a), .b(b),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .flags_en(flags_en), .flags_in(flags_in), .flags(flags),
    .cond(cond), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  logic [7:0] m_regs [8];
  logic [7:0] m_a, m_b;
  logic [3:0] m_flags;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic exp_cond(input logic [3:0] f, input logic [2:0] c);
    logic z, n, cy, v;
    {z, n, cy, v} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      3'd5: return n;
      3'd6: return n != v;
      default: return n == v;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] sel);
    if (sel == 3'd0) return 8'h00;
    if (wr_en && wr_sel == sel) return wr_data;
    return m_regs[sel];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_a = 8'h00; m_b = 8'h00; m_flags = 4'h0;
  endtask

  // One clock edge: step the model from the inputs currently driven, then
  // sample the DUT just after the edge.
  task automatic tick();
    logic [7:0] na, nb;
    if (!rst) begin
      na = hold ? m_a : m_read(rd_a_sel);
      nb = hold ? m_b : m_read(rd_b_sel);
      if (wr_en && wr_sel != 3'd0) m_regs[wr_sel] = wr_data;
      if (flags_en) m_flags = flags_in;
      m_a = na; m_b = nb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".a"}, a, m_a);
    check({tag, ".b"}, b, m_b);
    check({tag, ".flags"}, flags, m_flags);
  endtask

  task automatic check_all_conds(input string tag);
    for (int c = 0; c < 8; c++) begin
      cond = c[2:0];
      #0.1;
      check($sformatf("%s.cond%0d", tag, c), cond_true, exp_cond(m_flags, c[2:0]));
    end
  endtask

  task automatic idle();
    wr_en = 0; flags_en = 0; hold = 0;
  endtask

  task automatic wr(input logic [2:0] s, input logic [7:0] d);
    wr_en = 1; wr_sel = s; wr_data = d;
  endtask

  // Asynchronous reset asserted mid-cycle, released mid-cycle.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1;
    model_reset();
    #1;
    check_state(tag);
    check_all_conds(tag);
    @(posedge clk);
    #3;
    rst = 0;
  endtask

  logic [8:0] sum;
  logic [3:0] alu_f;

  initial begin
    rst = 1; idle();
    rd_a_sel = 0; rd_b_sel = 0; wr_sel = 0; wr_data = 0; flags_in = 0; cond = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check_state("por");
    check_all_conds("por");
    rst = 0;
    @(posedge clk); #1;

    // Load r3 and put it on a, then reset mid-cycle.
    wr(3, 8'h5a); flags_in = 4'hf; flags_en = 1; tick();
    idle(); rd_a_sel = 3; rd_b_sel = 3; tick();
    check("pre_rst.a", a, 8'h5a);
    mid_reset("rst");
    idle(); rd_a_sel = 3; tick();
    check("post_rst.r3", a, 8'h00);

    // Write/read
    wr(1, 8'h12); tick();
    wr(2, 8'hff); tick();
    idle(); rd_a_sel = 1; rd_b_sel = 2; tick();
    check("rd.a", a, 8'h12);
    check("rd.b", b, 8'hff);
    wr(0, 8'h77); tick();
    idle(); rd_a_sel = 0; rd_b_sel = 0; tick();
    check("r0.a", a, 8'h00);
    wr(0, 8'h77); rd_a_sel = 0; tick();
    check("r0.bypass", a, 8'h00);

    // Bypass
    wr(4, 8'h01); tick();
    wr(4, 8'h80); rd_a_sel = 4; rd_b_sel = 4; tick();
    check("byp.a", a, 8'h80);
    check("byp.b", b, 8'h80);

    // Hold
    idle(); wr(1, 8'h12); rd_a_sel = 1; tick();
    check("hold.pre", a, 8'h12);
    hold = 1; wr(1, 8'h34); rd_a_sel = 1; tick();
    check("hold.a", a, 8'h12);
    idle(); rd_a_sel = 1; tick();
    check("hold.rel", a, 8'h34);

    // Flags / conditions
    flags_en = 1; flags_in = 4'b0101; tick();
    check("fl.0101", flags, 4'b0101);
    cond = 6; #0.1; check("fl.LT", cond_true, 1'b0);
    cond = 7; #0.1; check("fl.GE", cond_true, 1'b1);
    cond = 5; #0.1; check("fl.MI", cond_true, 1'b1);
    cond = 1; #0.1; check("fl.EQ", cond_true, 1'b0);
    flags_in = 4'b1000; tick();
    cond = 1; #0.1; check("fl.EQ2", cond_true, 1'b1);
    cond = 2; #0.1; check("fl.NE2", cond_true, 1'b0);
    flags_en = 0; flags_in = 4'b0011; tick();
    check("fl.keep", flags, 4'b1000);

    // ALU loop: r1+r2 -> r3 with flags
    idle(); wr(1, 8'hff); tick();
    wr(2, 8'h01); tick();
    idle(); rd_a_sel = 1; rd_b_sel = 2; tick();
    sum = {1'b0, a} + {1'b0, b};
    alu_f[3] = (sum[7:0] == 8'h00);
    alu_f[2] = sum[7];
    alu_f[1] = sum[8];
    alu_f[0] = (a[7] == b[7]) && (sum[7] != a[7]);
    wr(3, sum[7:0]); flags_en = 1; flags_in = alu_f; tick();
    idle(); rd_a_sel = 3; tick();
    check("alu.r3", a, 8'h00);
    check("alu.flags", flags, 4'b1010);
    cond = 1; #0.1; check("alu.EQ", cond_true, 1'b1);
    cond = 3; #0.1; check("alu.CS", cond_true, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      rd_a_sel = 3'($urandom);
      rd_b_sel = 3'($urandom);
      wr_sel   = 3'($urandom);
      wr_data  = 8'($urandom);
      wr_en    = 1'($urandom);
      hold     = ($urandom_range(0, 3) == 0);
      flags_en = 1'($urandom);
      flags_in = 4'($urandom);
      tick();
      check_state($sformatf("rnd%0d", i));
      cond = 3'($urandom);
      #0.1;
      check($sformatf("rnd%0d.cond", i), cond_true, exp_cond(m_flags, cond));
      if ($urandom_range(0, 99) == 0) mid_reset($sformatf("rnd%0d.rst", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
